// File: rtl/rf2p_fifo_ctrl.sv
// FIFO controller in front of a 2-port register-file macro with 1-cycle registered read.
// A 2-entry output buffer absorbs the read latency so the consumer sees 1 pop/cycle.
module rf2p_fifo_ctrl #(
    parameter int NB_DATA = 16,
    parameter int L_DATA  = 17,
    parameter int L_ADDR  = $clog2(NB_DATA),
    parameter int L_CNT   = $clog2(NB_DATA + 3)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              push,
    input  logic [L_DATA-1:0] push_data,
    output logic              full,
    output logic              overflow,
    output logic              out_valid,
    output logic [L_DATA-1:0] out_data,
    input  logic              out_ready,
    output logic [L_CNT-1:0]  count,
    output logic              rf_wEn,
    output logic [L_ADDR-1:0] rf_wAddr,
    output logic [L_DATA-1:0] rf_wData,
    output logic              rf_rEn,
    output logic [L_ADDR-1:0] rf_rAddr,
    input  logic [L_DATA-1:0] rf_rData
);

    logic [L_ADDR-1:0] wr_ptr, rd_ptr;
    logic [L_CNT-1:0]  mem_cnt;
    logic              inflight;
    logic [1:0]        ob_cnt;
    logic [L_DATA-1:0] ob_head, ob_tail;
    logic              wr_fire, rd_fire, pop;

    assign full      = (mem_cnt == L_CNT'(NB_DATA));
    assign out_valid = (ob_cnt != 2'd0);
    assign out_data  = ob_head;
    assign count     = mem_cnt + L_CNT'(ob_cnt) + L_CNT'(inflight);

    // Gating with rst_n keeps the macro enables inactive while reset is held.
    assign pop     = out_valid & out_ready & ~clear;
    assign wr_fire = rst_n & ~clear & push & ~full;
    // Issue a read only if the buffer will have room when the data returns.
    assign rd_fire = rst_n & ~clear & (mem_cnt != '0) &
                     ((3'(ob_cnt) + 3'(inflight)) < (3'd2 + 3'(pop)));

    assign rf_wEn   = ~wr_fire;
    assign rf_wAddr = wr_ptr;
    assign rf_wData = push_data;
    assign rf_rEn   = ~rd_fire;
    assign rf_rAddr = rd_ptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            mem_cnt  <= '0;
            inflight <= 1'b0;
            overflow <= 1'b0;
        end else if (clear) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            mem_cnt  <= '0;
            inflight <= 1'b0;
            overflow <= 1'b0;
        end else begin
            if (wr_fire)
                wr_ptr <= (wr_ptr == L_ADDR'(NB_DATA - 1)) ? '0 : wr_ptr + 1'b1;
            if (rd_fire)
                rd_ptr <= (rd_ptr == L_ADDR'(NB_DATA - 1)) ? '0 : rd_ptr + 1'b1;
            mem_cnt  <= mem_cnt + L_CNT'(wr_fire) - L_CNT'(rd_fire);
            inflight <= rd_fire;
            if (push && full)
                overflow <= 1'b1;
        end
    end

    // Output buffer: head is what the consumer sees, tail holds the second entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ob_cnt  <= 2'd0;
            ob_head <= '0;
            ob_tail <= '0;
        end else if (clear) begin
            ob_cnt  <= 2'd0;
            ob_head <= '0;
            ob_tail <= '0;
        end else begin
            case ({inflight, pop})
                2'b10: begin
                    if (ob_cnt == 2'd0) ob_head <= rf_rData;
                    else                ob_tail <= rf_rData;
                    ob_cnt <= ob_cnt + 2'd1;
                end
                2'b01: begin
                    ob_head <= ob_tail;
                    ob_cnt  <= ob_cnt - 2'd1;
                end
                2'b11: begin
                    if (ob_cnt == 2'd1) begin
                        ob_head <= rf_rData;
                    end else begin
                        ob_head <= ob_tail;
                        ob_tail <= rf_rData;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_rf2p_fifo_ctrl.sv
// Directed bench for rf2p_fifo_ctrl: a 16-deep instance plus a 12-deep one, each with an RF model.
module tb_rf2p_fifo_ctrl;

    logic        clk;
    logic        rst_n, clear, push, out_ready;
    logic [16:0] push_data, out_data, rf_wData, rf_rData;
    logic        full, overflow, out_valid, rf_wEn, rf_rEn;
    logic [4:0]  count;
    logic [3:0]  rf_wAddr, rf_rAddr;

    logic        rst_b, clear_b, push_b, out_ready_b;
    logic [16:0] push_data_b, out_data_b, rf_wData_b, rf_rData_b;
    logic        full_b, overflow_b, out_valid_b, rf_wEn_b, rf_rEn_b;
    logic [3:0]  count_b;
    logic [3:0]  rf_wAddr_b, rf_rAddr_b;

    logic [16:0] mem_a [0:15];
    logic [16:0] mem_b [0:15];

    int vectors = 0;
    int miscompares = 0;

    rf2p_fifo_ctrl #(.NB_DATA(16), .L_DATA(17)) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear), .push(push), .push_data(push_data),
        .full(full), .overflow(overflow), .out_valid(out_valid), .out_data(out_data),
        .out_ready(out_ready), .count(count), .rf_wEn(rf_wEn), .rf_wAddr(rf_wAddr),
        .rf_wData(rf_wData), .rf_rEn(rf_rEn), .rf_rAddr(rf_rAddr), .rf_rData(rf_rData)
    );

    rf2p_fifo_ctrl #(.NB_DATA(12), .L_DATA(17)) dut12 (
        .clk(clk), .rst_n(rst_b), .clear(clear_b), .push(push_b), .push_data(push_data_b),
        .full(full_b), .overflow(overflow_b), .out_valid(out_valid_b), .out_data(out_data_b),
        .out_ready(out_ready_b), .count(count_b), .rf_wEn(rf_wEn_b), .rf_wAddr(rf_wAddr_b),
        .rf_wData(rf_wData_b), .rf_rEn(rf_rEn_b), .rf_rAddr(rf_rAddr_b), .rf_rData(rf_rData_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register-file macro models: write on wEn low, registered read on rEn low.
    always @(posedge clk) begin
        if (!rf_wEn) mem_a[rf_wAddr] <= rf_wData;
        if (!rf_rEn) rf_rData <= mem_a[rf_rAddr];
        if (!rf_wEn_b) mem_b[rf_wAddr_b] <= rf_wData_b;
        if (!rf_rEn_b) rf_rData_b <= mem_b[rf_rAddr_b];
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; clear = 1'b0; push = 1'b0; push_data = '0; out_ready = 1'b0;
        rst_b = 1'b0; clear_b = 1'b0; push_b = 1'b0; push_data_b = '0; out_ready_b = 1'b0;
        #12;
        vectors++; if (count !== 5'd0) begin miscompares++; $display("FAIL reset_count: got %0d want 0", count); end
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid: got %0b want 0", out_valid); end
        vectors++; if (full !== 1'b0 || overflow !== 1'b0) begin miscompares++; $display("FAIL reset_flags: got full=%0b ovf=%0b want 0/0", full, overflow); end
        vectors++; if (rf_wEn !== 1'b1 || rf_rEn !== 1'b1) begin miscompares++; $display("FAIL reset_enables: got w=%0b r=%0b want 1/1", rf_wEn, rf_rEn); end
        vectors++; if (out_data !== 17'd0) begin miscompares++; $display("FAIL reset_out_data: got %0h want 0", out_data); end
        step();
        rst_n = 1'b1; rst_b = 1'b1;
        step();
    endtask

    task automatic test_latency();
        push = 1'b1; push_data = 17'h00001;
        #1;
        vectors++; if (rf_wEn !== 1'b0 || rf_wAddr !== 4'd0) begin miscompares++; $display("FAIL lat_c0_write: got wEn=%0b wAddr=%0d want 0/0", rf_wEn, rf_wAddr); end
        step(); push = 1'b0; #1;
        vectors++; if (rf_rEn !== 1'b0 || rf_rAddr !== 4'd0) begin miscompares++; $display("FAIL lat_c1_read: got rEn=%0b rAddr=%0d want 0/0", rf_rEn, rf_rAddr); end
        vectors++; if (count !== 5'd1) begin miscompares++; $display("FAIL lat_c1_count: got %0d want 1", count); end
        step(); #1;
        vectors++; if (count !== 5'd1 || out_valid !== 1'b0) begin miscompares++; $display("FAIL lat_c2: got count=%0d valid=%0b want 1/0", count, out_valid); end
        step(); #1;
        vectors++; if (out_valid !== 1'b1 || out_data !== 17'h00001 || count !== 5'd1) begin miscompares++; $display("FAIL lat_c3: got valid=%0b data=%0h count=%0d want 1/1/1", out_valid, out_data, count); end
        out_ready = 1'b1;
        step(); out_ready = 1'b0; #1;
        vectors++; if (count !== 5'd0 || out_valid !== 1'b0) begin miscompares++; $display("FAIL lat_pop: got count=%0d valid=%0b want 0/0", count, out_valid); end
        step();
    endtask

    task automatic test_fill_overflow();
        out_ready = 1'b0;
        for (int i = 0; i < 18; i++) begin
            push = 1'b1; push_data = 17'(i);
            step();
        end
        push = 1'b1; push_data = 17'd99;
        #1;
        vectors++; if (full !== 1'b1 || count !== 5'd18) begin miscompares++; $display("FAIL fill_full: got full=%0b count=%0d want 1/18", full, count); end
        vectors++; if (rf_wEn !== 1'b1) begin miscompares++; $display("FAIL fill_wen_blocked: got %0b want 1", rf_wEn); end
        step(); push = 1'b0; #1;
        vectors++; if (overflow !== 1'b1 || count !== 5'd18) begin miscompares++; $display("FAIL fill_overflow: got ovf=%0b count=%0d want 1/18", overflow, count); end
        out_ready = 1'b1;
        for (int i = 0; i < 18; i++) begin
            #1;
            vectors++; if (out_valid !== 1'b1 || out_data !== 17'(i)) begin miscompares++; $display("FAIL drain_order[%0d]: got valid=%0b data=%0d want 1/%0d", i, out_valid, out_data, i); end
            step();
        end
        #1;
        vectors++; if (out_valid !== 1'b0 || count !== 5'd0 || full !== 1'b0) begin miscompares++; $display("FAIL drain_empty: got valid=%0b count=%0d full=%0b want 0/0/0", out_valid, count, full); end
        out_ready = 1'b0;
        step();
        clear = 1'b1;
        step(); clear = 1'b0; #1;
        vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL clear_overflow: got %0b want 0", overflow); end
        step();
    endtask

    task automatic test_stream();
        out_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            push = 1'b1; push_data = 17'(i);
            step();
        end
        push = 1'b0;
        step(); step(); #1;
        vectors++; if (count !== 5'd10) begin miscompares++; $display("FAIL stream_fill: got %0d want 10", count); end
        step();
        for (int i = 0; i < 40; i++) begin
            push = 1'b1; push_data = 17'(10 + i); out_ready = 1'b1;
            #1;
            vectors++; if (out_valid !== 1'b1 || out_data !== 17'(i) || count !== 5'd10) begin miscompares++; $display("FAIL stream[%0d]: got valid=%0b data=%0d count=%0d want 1/%0d/10", i, out_valid, out_data, count, i); end
            step();
        end
        push = 1'b0;
        for (int i = 40; i < 50; i++) begin
            #1;
            vectors++; if (out_valid !== 1'b1 || out_data !== 17'(i)) begin miscompares++; $display("FAIL stream_tail[%0d]: got valid=%0b data=%0d want 1/%0d", i, out_valid, out_data, i); end
            step();
        end
        out_ready = 1'b0; #1;
        vectors++; if (count !== 5'd0) begin miscompares++; $display("FAIL stream_empty: got %0d want 0", count); end
        step();
    endtask

    task automatic test_nb12();
        int txi, rxi;
        logic acc;
        txi = 0; rxi = 0;
        for (int cyc = 0; cyc < 800 && rxi < 50; cyc++) begin
            push_b = (txi < 50) && ($urandom_range(0, 3) != 0);
            push_data_b = 17'(txi);
            out_ready_b = 1'($urandom_range(0, 1));
            #1;
            acc = push_b && !full_b;
            vectors++; if (rf_wAddr_b > 4'd11 || rf_rAddr_b > 4'd11) begin miscompares++; $display("FAIL nb12_addr: got w=%0d r=%0d want <=11", rf_wAddr_b, rf_rAddr_b); end
            if (out_valid_b && out_ready_b) begin
                vectors++; if (out_data_b !== 17'(rxi)) begin miscompares++; $display("FAIL nb12_order: got %0d want %0d", out_data_b, rxi); end
                rxi++;
            end
            if (acc) txi++;
            step();
        end
        push_b = 1'b0; out_ready_b = 1'b0;
        vectors++; if (rxi != 50) begin miscompares++; $display("FAIL nb12_timeout: got %0d items want 50", rxi); end
        #1;
        vectors++; if (count_b !== 4'd0 || out_valid_b !== 1'b0) begin miscompares++; $display("FAIL nb12_empty: got count=%0d valid=%0b want 0/0", count_b, out_valid_b); end
        step();
    endtask

    task automatic test_clear_inflight();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            push = 1'b1; push_data = 17'(5 + i);
            step();
        end
        push = 1'b0; #1;
        vectors++; if (count !== 5'd3 || out_valid !== 1'b1) begin miscompares++; $display("FAIL clr_pre: got count=%0d valid=%0b want 3/1", count, out_valid); end
        clear = 1'b1; push = 1'b1; push_data = 17'h1ffff; out_ready = 1'b1;
        step();
        clear = 1'b0; push = 1'b0; out_ready = 1'b0; #1;
        vectors++; if (count !== 5'd0 || out_valid !== 1'b0 || rf_rEn !== 1'b1) begin miscompares++; $display("FAIL clr_next: got count=%0d valid=%0b rEn=%0b want 0/0/1", count, out_valid, rf_rEn); end
        step(); #1;
        vectors++; if (count !== 5'd0 || out_valid !== 1'b0) begin miscompares++; $display("FAIL clr_discard: got count=%0d valid=%0b want 0/0", count, out_valid); end
        push = 1'b1; push_data = 17'h1abcd;
        #1;
        vectors++; if (rf_wAddr !== 4'd0) begin miscompares++; $display("FAIL clr_wptr: got %0d want 0", rf_wAddr); end
        step(); push = 1'b0; #1;
        vectors++; if (rf_rEn !== 1'b0 || rf_rAddr !== 4'd0) begin miscompares++; $display("FAIL clr_rptr: got rEn=%0b rAddr=%0d want 0/0", rf_rEn, rf_rAddr); end
        step(); step(); #1;
        vectors++; if (out_valid !== 1'b1 || out_data !== 17'h1abcd) begin miscompares++; $display("FAIL clr_after: got valid=%0b data=%0h want 1/1abcd", out_valid, out_data); end
        out_ready = 1'b1;
        step(); out_ready = 1'b0;
        step();
    endtask

    task automatic test_async_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 18; i++) begin
            push = 1'b1; push_data = 17'(i);
            step();
        end
        push = 1'b1; push_data = 17'd77;
        #2;
        vectors++; if (full !== 1'b1) begin miscompares++; $display("FAIL arst_pre_full: got %0b want 1", full); end
        rst_n = 1'b0;
        #1;
        vectors++; if (out_valid !== 1'b0 || full !== 1'b0 || count !== 5'd0) begin miscompares++; $display("FAIL arst_state: got valid=%0b full=%0b count=%0d want 0/0/0", out_valid, full, count); end
        vectors++; if (rf_wEn !== 1'b1 || rf_rEn !== 1'b1) begin miscompares++; $display("FAIL arst_enables: got w=%0b r=%0b want 1/1", rf_wEn, rf_rEn); end
        push = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        test_latency();
    endtask

    initial begin
        test_reset();
        test_latency();
        test_fill_overflow();
        test_stream();
        test_nb12();
        test_clear_inflight();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
